hash_stream_host: RTL and testbench
===================================

// Module: hash_stream_host
// PURPOSE
//  Host side of the byte-stream hashing interface: drives start/data/finish into
//  the data manager, then collects the W-byte digest stream it returns. Pulls
//  message bytes from an upstream valid/ready source and presents the assembled
//  digest as one word. Sits between the command/IO front end and data_mgr.
// PARAMETERS
//  W        32     digest bytes; digest is W*8 bits, must match data_mgr W
//  LEN_W    16     width of message byte count
//  TIMEOUT  4096   max cycles in WAIT before err; 0 disables timeout
//  MASK     0      W*8-bit constant XORed into the collected digest (unmask)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  cmd_go       in   1       pulse: start a hash of cmd_len bytes
//  cmd_len      in   LEN_W   message length in bytes, sampled on accepted cmd_go
//  src_data     in   8       upstream message byte
//  src_valid    in   1       upstream byte valid
//  src_ready    out  1       byte accepted when src_valid & src_ready
//  dm_data      out  8       byte to data manager
//  dm_dv        out  1       dm_data valid (one byte per cycle)
//  dm_drdy      in   1       data manager may take a byte; tie 1 if unused
//  dm_start     out  1       one-cycle session reset to data manager
//  dm_finish    out  1       final-block request, level
//  dm_dout      in   8       digest byte from data manager, LSB byte first
//  dm_dvout     in   1       dm_dout valid
//  dm_dend      in   1       last digest byte marker
//  digest       out  W*8     assembled digest ^ MASK; held until next cmd_go
//  digest_valid out  1       one-cycle pulse when digest updated
//  busy         out  1       high in any state except IDLE
//  err          out  1       sticky until next accepted cmd_go or rst
// BEHAVIOUR
//  Reset: all outputs 0, digest 0, FSM IDLE, counters 0. rst mid-session aborts
//   immediately to IDLE; no dm_start/dm_finish emitted; digest unchanged by rst? no: cleared.
//  FSM IDLE->START->SEND->FIN->WAIT->DONE->IDLE.
//  IDLE: cmd_go latches cmd_len to rem, clears err, rx_cnt=0 -> START. cmd_go
//   outside IDLE ignored.
//  START: dm_start=1 one cycle, dm_dv=0, dm_finish=0 (never with start) -> SEND,
//   or -> FIN directly if rem==0.
//  SEND: src_ready = dm_drdy & (rem!=0); on handshake dm_data<=src_data,
//   dm_dv<=1 (registered, 1-cycle latency), rem-=1; rem reaching 0 -> FIN.
//   dm_dv is 0 in any cycle with no handshake. Bytes never dropped/duplicated.
//  FIN: dm_finish=1 and held through WAIT until DONE (receiver latches its
//   finish flag, so exactly one final strobe). dm_dv=0 from FIN onward -> WAIT.
//  WAIT: each dm_dvout byte written to digest_buf[8*rx_cnt +: 8], rx_cnt+=1.
//   dm_dend with rx_cnt==W-1 -> DONE. dm_dend on any other index, or dm_dvout
//   after W bytes, sets err -> IDLE (digest not updated). Cycle counter from
//   WAIT entry; reaching TIMEOUT sets err -> IDLE.
//  DONE: digest<=digest_buf^MASK, digest_valid=1 for this cycle, dm_finish=0 -> IDLE.
//  Digest bytes arriving outside WAIT are ignored and set err.
//  rx_cnt width clog2(W)+1; rem width LEN_W, no wrap (decrement only when !=0).
// STRUCTURE
//  Shared package: FSM state enum (IDLE,START,SEND,FIN,WAIT,DONE), W default,
//   MASK constant shared with the data manager.
//  One sub-module natural: digest_collector (byte-serial to W*8 deserializer
//   with index/end-marker check); FSM, length counter, timeout in top.
// TESTING
//  cmd_len=3, bytes 61 62 63 -> dm_start 1 cycle, dm_dv 3 cycles, then
//   dm_finish; W-byte return 00..1F -> digest=0x1F1E..0100, digest_valid 1 cycle.
//  cmd_len=0 -> dm_start then dm_finish, dm_dv never high; digest as returned.
//  cmd_len=64, src_valid toggling 1/0 and dm_drdy low every 3rd cycle -> exactly
//   64 dm_dv bytes in order, no byte when dm_drdy=0.
//  dm_dend on byte 10 -> err=1, busy=0, digest keeps prior value, no digest_valid.
//  No digest return, TIMEOUT=16 -> err=1 at cycle 16 of WAIT, dm_finish drops.
//  rst asserted in SEND after 5 bytes -> next cycle all outputs 0, IDLE; new
//   cmd_go runs a full session normally; cmd_go while busy has no effect.

Source files
------------

// File: rtl/hash_stream_host_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_stream_host_pkg                                                     |
// | Types and constants shared by the hash stream host and the data manager: |
// | host FSM state encoding, default digest size and the digest unmask.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package hash_stream_host_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SEND  = 3'd2,
    FIN   = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Digest size in bytes; the data manager must be built with the same value.
  localparam int DIGEST_BYTES = 32;

  // XOR unmask applied to the collected digest. Sized for the widest digest
  // in use; narrower hosts take the low bytes.
  localparam logic [255:0] DM_MASK = '0;

endpackage
`default_nettype wire

// File: rtl/hash_stream_host_digest_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_stream_host_digest_collector                                        |
// | Byte-serial to W*8-bit deserializer for the returned digest. Byte k      |
// | lands in bits [8k +: 8] (LSB byte first). Flags a clean end when the end |
// | marker rides on byte W-1, and a protocol error when the marker comes on  |
// | any other byte or a byte arrives after W bytes.                          |
// | Ports: clk, rst    - clock, synchronous active-high reset                |
// |        clear       - restart at byte 0 (new session)                     |
// |        en          - collection window open                              |
// |        byte_in/vld/end - digest byte, valid, last-byte marker            |
// |        assembled   - collected bytes                                     |
// |        done, bad   - same-cycle end/error indications                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hash_stream_host_digest_collector #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           en,
  input  logic [7:0]     byte_in,
  input  logic           byte_vld,
  input  logic           byte_end,
  output logic [W*8-1:0] assembled,
  output logic           done,
  output logic           bad
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
  localparam logic [CW-1:0] NUM_BYTES = CW'(W);

  logic [CW-1:0] rx_cnt;
  logic          in_range;
  logic          wr;

  assign in_range = (rx_cnt < NUM_BYTES);
  assign wr       = en & byte_vld & in_range;

  always_comb begin
    done = en & byte_vld & byte_end & (rx_cnt == LAST_IDX);
    // Overflow, or a marker that does not sit on the final byte.
    bad  = en & byte_vld & (~in_range | (byte_end & (rx_cnt != LAST_IDX)));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rx_cnt <= '0;
    end else if (wr) begin
      rx_cnt <= rx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assembled <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (wr && (rx_cnt == CW'(i))) begin
          assembled[8*i +: 8] <= byte_in;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hash_stream_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_stream_host                                                         |
// | Host side of the byte-stream hashing interface. On cmd_go it opens a     |
// | data-manager session (dm_start), forwards cmd_len bytes from the         |
// | upstream valid/ready source, requests the final block (dm_finish), then  |
// | collects the W-byte digest and presents it (unmasked) as one word.       |
// | Ports: cmd_go/cmd_len      - command in                                  |
// |        src_*               - upstream message bytes (valid/ready)        |
// |        dm_data/dv/drdy     - byte stream to the data manager             |
// |        dm_start/dm_finish  - session control to the data manager         |
// |        dm_dout/dvout/dend  - digest byte stream back                     |
// |        digest/digest_valid - result word and update pulse                |
// |        busy, err           - status (err sticky until next command)      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hash_stream_host
  import hash_stream_host_pkg::*;
#(
  parameter int             W       = DIGEST_BYTES,
  parameter int             LEN_W   = 16,
  parameter int             TIMEOUT = 4096,
  parameter logic [W*8-1:0] MASK    = (W*8)'(DM_MASK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_go,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [7:0]       dm_data,
  output logic             dm_dv,
  input  logic             dm_drdy,
  output logic             dm_start,
  output logic             dm_finish,
  input  logic [7:0]       dm_dout,
  input  logic             dm_dvout,
  input  logic             dm_dend,
  output logic [W*8-1:0]   digest,
  output logic             digest_valid,
  output logic             busy,
  output logic             err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_nx;
  logic [LEN_W-1:0] rem;
  logic [TW-1:0]    wait_cnt;
  logic [W*8-1:0]   col_buf;
  logic             col_done, col_bad;
  logic             accept, rem_zero, take, timed_out, stray, wait_fail;

  assign accept    = (state == IDLE) & cmd_go;
  assign rem_zero  = (rem == '0);
  assign src_ready = (state == SEND) & dm_drdy & ~rem_zero;
  assign take      = src_valid & src_ready;
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == T_LAST);
  assign stray     = dm_dvout & (state != WAIT);
  assign wait_fail = (state == WAIT) & ~col_done & (col_bad | timed_out);

  hash_stream_host_digest_collector #(
    .W (W)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .en        (state == WAIT),
    .byte_in   (dm_dout),
    .byte_vld  (dm_dvout),
    .byte_end  (dm_dend),
    .assembled (col_buf),
    .done      (col_done),
    .bad       (col_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    dm_start  = 1'b0;
    dm_finish = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (cmd_go) state_nx = START;
      START: begin
        dm_start = 1'b1;
        state_nx = rem_zero ? FIN : SEND;
      end
      // Leave only once rem is already zero, so the last forwarded byte's
      // registered dm_dv has gone out before dm_finish rises.
      SEND:  if (rem_zero) state_nx = FIN;
      FIN: begin
        dm_finish = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        dm_finish = 1'b1;
        if (col_done)       state_nx = DONE;
        else if (wait_fail) state_nx = IDLE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem          <= '0;
      dm_data      <= '0;
      dm_dv        <= 1'b0;
      wait_cnt     <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      dm_dv <= take;
      if (take) dm_data <= src_data;

      if (accept)    rem <= cmd_len;
      else if (take) rem <= rem - 1'b1;

      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;

      digest_valid <= (state == DONE);
      if (state == DONE) digest <= col_buf ^ MASK;

      // A new error in the same cycle as a command wins over the clear.
      if (stray || wait_fail) err <= 1'b1;
      else if (accept)        err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hash_stream_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hash_stream_host                                                      |
// | Directed self-checking bench for hash_stream_host. A second instance     |
// | with TIMEOUT=16 shares the inputs and is examined for the timeout case.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hash_stream_host;

  localparam int W     = 32;
  localparam int LEN_W = 16;

  localparam logic [255:0] DIG_00 =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] DIG_40 =
    256'h5f5e5d5c5b5a595857565554535251504f4e4d4c4b4a49484746454443424140;
  localparam logic [255:0] DIG_80 =
    256'h9f9e9d9c9b9a999897969594939291908f8e8d8c8b8a89888786858483828180;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             cmd_go = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [7:0]       src_data = '0;
  logic             src_valid = 1'b0;
  logic             dm_drdy = 1'b1;
  logic [7:0]       dm_dout = '0;
  logic             dm_dvout = 1'b0;
  logic             dm_dend = 1'b0;

  logic             src_ready, dm_dv, dm_start, dm_finish, digest_valid, busy, err;
  logic [7:0]       dm_data;
  logic [W*8-1:0]   digest;

  logic             to_src_ready, to_dm_dv, to_dm_start, to_dm_finish;
  logic             to_digest_valid, to_busy, to_err;
  logic [7:0]       to_dm_data;
  logic [W*8-1:0]   to_digest;

  hash_stream_host #(.W(W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_go(cmd_go), .cmd_len(cmd_len),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .dm_data(dm_data), .dm_dv(dm_dv), .dm_drdy(dm_drdy),
    .dm_start(dm_start), .dm_finish(dm_finish),
    .dm_dout(dm_dout), .dm_dvout(dm_dvout), .dm_dend(dm_dend),
    .digest(digest), .digest_valid(digest_valid), .busy(busy), .err(err)
  );

  hash_stream_host #(.W(W), .LEN_W(LEN_W), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .cmd_go(cmd_go), .cmd_len(cmd_len),
    .src_data(src_data), .src_valid(src_valid), .src_ready(to_src_ready),
    .dm_data(to_dm_data), .dm_dv(to_dm_dv), .dm_drdy(dm_drdy),
    .dm_start(to_dm_start), .dm_finish(to_dm_finish),
    .dm_dout(dm_dout), .dm_dvout(dm_dvout), .dm_dend(dm_dend),
    .digest(to_digest), .digest_valid(to_digest_valid), .busy(to_busy), .err(to_err)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] msg [0:63];
  logic [7:0] rec [0:255];
  int dv_cnt = 0, start_cnt = 0, dval_cnt = 0, viol_cnt = 0;

  // Observer of the main instance's data-manager side.
  always @(negedge clk) begin
    if (dm_dv) begin
      rec[dv_cnt % 256] = dm_data;
      dv_cnt++;
    end
    if (dm_start) start_cnt++;
    if (digest_valid) dval_cnt++;
    if ((dm_start && dm_finish) || (dm_dv && dm_finish) || (src_ready && !dm_drdy))
      viol_cnt++;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cmd_go = 1'b0; src_valid = 1'b0; dm_dvout = 1'b0; dm_dend = 1'b0;
    dm_drdy = 1'b1;
    cyc; cyc;
    rst = 1'b0;
    cyc;
  endtask

  task automatic send_cmd(input int len);
    cmd_go = 1'b1; cmd_len = LEN_W'(len);
    cyc;
    cmd_go = 1'b0;
  endtask

  // mode 0: source and data manager always ready.
  // mode 1: src_valid toggles, dm_drdy low every third cycle.
  task automatic feed(input int n, input int mode, output int got);
    int idx = 0;
    int c = 0;
    bit hs;
    while (idx < n && c < 2000) begin
      src_data = msg[idx];
      if (mode == 0) begin
        src_valid = 1'b1; dm_drdy = 1'b1;
      end else begin
        src_valid = (c % 2 == 0); dm_drdy = (c % 3 != 2);
      end
      @(negedge clk);
      hs = src_valid && src_ready;
      cyc;
      if (hs) idx++;
      c++;
    end
    src_valid = 1'b0; dm_drdy = 1'b1;
    got = idx;
  endtask

  // Returns positioned in the first WAIT cycle.
  task automatic wait_finish(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dm_finish) begin ok = 1'b1; break; end
      cyc;
    end
    cyc;
  endtask

  task automatic return_digest(input int n, input int dend_idx, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      dm_dvout = 1'b1;
      dm_dout  = base + 8'(i);
      dm_dend  = (i == dend_idx);
      cyc;
    end
    dm_dvout = 1'b0; dm_dend = 1'b0;
  endtask

  task automatic wait_dvalid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (digest_valid) begin seen = 1'b1; cyc; break; end
      cyc;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc; cyc;
    @(negedge clk);
    total++;
    if ({src_ready, dm_dv, dm_start, dm_finish, digest_valid, busy, err} !== 7'd0)
      $display("FAIL reset_outputs got %b want 0000000",
               {src_ready, dm_dv, dm_start, dm_finish, digest_valid, busy, err});
    else passed++;
    total++;
    if (digest !== '0) $display("FAIL reset_digest got %h want 0", digest);
    else passed++;
    rst = 1'b0;
    cyc;
  endtask

  task automatic test_basic;
    int s0 = start_cnt, d0 = dv_cnt, v0 = dval_cnt, x0 = viol_cnt;
    int got;
    bit ok, seen;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_cmd(3);
    feed(3, 0, got);
    wait_finish(ok);
    return_digest(32, 31, 8'h00);
    wait_dvalid(seen);
    cyc; cyc;
    total++;
    if (got != 3 || !ok) $display("FAIL basic_flow got bytes=%0d fin=%0d want 3 1", got, ok);
    else passed++;
    total++;
    if (start_cnt - s0 != 1) $display("FAIL basic_start got %0d want 1", start_cnt - s0);
    else passed++;
    total++;
    if (dv_cnt - d0 != 3) $display("FAIL basic_dv_count got %0d want 3", dv_cnt - d0);
    else passed++;
    total++;
    if ({rec[d0 % 256], rec[(d0 + 1) % 256], rec[(d0 + 2) % 256]} !== 24'h616263)
      $display("FAIL basic_bytes got %h%h%h want 616263",
               rec[d0 % 256], rec[(d0 + 1) % 256], rec[(d0 + 2) % 256]);
    else passed++;
    total++;
    if (!seen || digest !== DIG_00) $display("FAIL basic_digest got %h want %h", digest, DIG_00);
    else passed++;
    total++;
    if (dval_cnt - v0 != 1) $display("FAIL basic_dvalid_pulses got %0d want 1", dval_cnt - v0);
    else passed++;
    total++;
    if (viol_cnt != x0) $display("FAIL basic_overlap got %0d want 0", viol_cnt - x0);
    else passed++;
    total++;
    if ({busy, err} !== 2'b00) $display("FAIL basic_status got %b want 00", {busy, err});
    else passed++;
  endtask

  task automatic test_bad_dend;
    logic [W*8-1:0] prev = digest;
    int v0 = dval_cnt;
    int got;
    bit ok;
    msg[0] = 8'h11;
    send_cmd(1);
    feed(1, 0, got);
    wait_finish(ok);
    return_digest(11, 10, 8'hA0);
    @(negedge clk);
    total++;
    if ({err, busy} !== 2'b10) $display("FAIL bad_dend_status got err,busy=%b want 10", {err, busy});
    else passed++;
    total++;
    if (digest !== prev) $display("FAIL bad_dend_digest got %h want %h", digest, prev);
    else passed++;
    cyc; cyc;
    total++;
    if (dval_cnt != v0) $display("FAIL bad_dend_dvalid got %0d want 0", dval_cnt - v0);
    else passed++;
  endtask

  task automatic test_zero_len;
    int s0 = start_cnt, d0 = dv_cnt;
    bit ok, seen;
    send_cmd(0);
    @(negedge clk);
    total++;
    if (err !== 1'b0) $display("FAIL zero_err_cleared got %b want 0", err);
    else passed++;
    cyc;
    wait_finish(ok);
    return_digest(32, 31, 8'h40);
    wait_dvalid(seen);
    total++;
    if (start_cnt - s0 != 1 || dv_cnt != d0 || !ok)
      $display("FAIL zero_ctrl got start=%0d dv=%0d fin=%0d want 1 0 1",
               start_cnt - s0, dv_cnt - d0, ok);
    else passed++;
    total++;
    if (!seen || digest !== DIG_40) $display("FAIL zero_digest got %h want %h", digest, DIG_40);
    else passed++;
  endtask

  task automatic test_flow;
    int d0 = dv_cnt, x0 = viol_cnt;
    int got, mism;
    bit ok, seen;
    for (int i = 0; i < 64; i++) msg[i] = 8'(i * 7 + 3);
    send_cmd(64);
    feed(64, 1, got);
    wait_finish(ok);
    return_digest(32, 31, 8'h00);
    wait_dvalid(seen);
    mism = 0;
    for (int i = 0; i < 64; i++)
      if (rec[(d0 + i) % 256] !== 8'(i * 7 + 3)) mism++;
    total++;
    if (got != 64 || dv_cnt - d0 != 64)
      $display("FAIL flow_count got taken=%0d dv=%0d want 64 64", got, dv_cnt - d0);
    else passed++;
    total++;
    if (mism != 0) $display("FAIL flow_order got %0d wrong bytes want 0", mism);
    else passed++;
    total++;
    if (viol_cnt != x0) $display("FAIL flow_drdy got %0d violations want 0", viol_cnt - x0);
    else passed++;
    total++;
    if (!seen || digest !== DIG_00) $display("FAIL flow_digest got %h want %h", digest, DIG_00);
    else passed++;
  endtask

  task automatic test_timeout;
    int fcnt = 0, early = 0;
    do_reset;
    send_cmd(0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (to_dm_finish) begin
        fcnt++;
        if (to_err) early++;
      end else if (fcnt > 0) begin
        break;
      end
      cyc;
    end
    // FIN cycle plus 16 WAIT cycles.
    total++;
    if (fcnt != 17) $display("FAIL timeout_finish_cycles got %0d want 17", fcnt);
    else passed++;
    total++;
    if (early != 0) $display("FAIL timeout_early_err got %0d want 0", early);
    else passed++;
    total++;
    if ({to_err, to_busy} !== 2'b10) $display("FAIL timeout_status got %b want 10", {to_err, to_busy});
    else passed++;
    cyc;
    do_reset;
  endtask

  task automatic test_rst_abort;
    int got, d0;
    bit ok, seen;
    for (int i = 0; i < 20; i++) msg[i] = 8'h30 + 8'(i);
    send_cmd(20);
    feed(5, 0, got);
    total++;
    if (got != 5) $display("FAIL abort_pre_bytes got %0d want 5", got);
    else passed++;
    rst = 1'b1; src_valid = 1'b1;
    cyc;
    @(negedge clk);
    total++;
    if ({src_ready, dm_dv, dm_start, dm_finish, digest_valid, busy, err} !== 7'd0 || digest !== '0)
      $display("FAIL abort_outputs got %b digest %h want 0000000 0",
               {src_ready, dm_dv, dm_start, dm_finish, digest_valid, busy, err}, digest);
    else passed++;
    rst = 1'b0; src_valid = 1'b0;
    cyc;
    d0 = dv_cnt;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_cmd(3);
    cmd_go = 1'b1; cmd_len = LEN_W'(9);
    feed(3, 0, got);
    wait_finish(ok);
    cmd_go = 1'b0;
    return_digest(32, 31, 8'h80);
    wait_dvalid(seen);
    total++;
    if (dv_cnt - d0 != 3 || !ok) $display("FAIL busy_cmd_ignored got dv=%0d want 3", dv_cnt - d0);
    else passed++;
    total++;
    if (!seen || digest !== DIG_80 || err !== 1'b0)
      $display("FAIL abort_rerun_digest got %h err %b want %h 0", digest, err, DIG_80);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bad_dend;
    test_zero_len;
    test_flow;
    test_timeout;
    test_rst_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
